// File: rtl/free_list_if.sv
// ---------------------------------------------------------------------------
// free_list_if: allocation / free / status bundle for the free-block manager.
//   alloc_req_i       requester -> manager, held until granted
//   alloc_gnt_o       manager -> requester, one-cycle grant pulse
//   alloc_block_idx_o granted block index, valid with alloc_gnt_o
//   free_req_i        return-block strobe, one block per cycle
//   free_block_idx_i  index being returned
//   init_done_o       initial fill complete
//   free_count_o      number of free blocks, 0..NUM_BLOCKS
//   overflow_err_o    sticky: free while full or during init
//   double_free_err_o sticky: freed index was not allocated
// The slave modport is the manager side; the master modport is the client side.
// ---------------------------------------------------------------------------
interface free_list_if #(
  parameter int unsigned NUM_BLOCKS = 1024,
  parameter int unsigned ADDR_W     = $clog2(NUM_BLOCKS)
);
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic              alloc_req_i;
  logic              alloc_gnt_o;
  logic [ADDR_W-1:0] alloc_block_idx_o;
  logic              free_req_i;
  logic [ADDR_W-1:0] free_block_idx_i;
  logic              init_done_o;
  logic [CNT_W-1:0]  free_count_o;
  logic              overflow_err_o;
  logic              double_free_err_o;

  modport slave (
    input  alloc_req_i,
    input  free_req_i,
    input  free_block_idx_i,
    output alloc_gnt_o,
    output alloc_block_idx_o,
    output init_done_o,
    output free_count_o,
    output overflow_err_o,
    output double_free_err_o
  );

  modport master (
    output alloc_req_i,
    output free_req_i,
    output free_block_idx_i,
    input  alloc_gnt_o,
    input  alloc_block_idx_o,
    input  init_done_o,
    input  free_count_o,
    input  overflow_err_o,
    input  double_free_err_o
  );
endinterface

// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list: free-block manager for the shared packet buffer.
// Keeps unused block indices in a circular FIFO. After reset it fills the
// FIFO with 0..NUM_BLOCKS-1 (INIT), then serves one allocation and one free
// per cycle (READY). An in-use bitmap rejects frees of unallocated indices.
// Ports:
//   clk  single clock
//   rst  synchronous reset, active-high
//   bus  free_list_if.slave (alloc/free handshake and status, see interface)
// ---------------------------------------------------------------------------
module free_list #(
  parameter int unsigned NUM_BLOCKS = 1024,
  parameter int unsigned ADDR_W     = $clog2(NUM_BLOCKS)
) (
  input  logic      clk,
  input  logic      rst,
  free_list_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_BLOCKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BLOCKS - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // State and storage
  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     fifo_q [NUM_BLOCKS];
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_BLOCKS-1:0] in_use_q, in_use_d;

  // Registered outputs
  logic                  gnt_q, gnt_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic                  init_done_q, init_done_d;
  logic                  ovf_q, ovf_d;
  logic                  dbl_q, dbl_d;

  // FIFO write port (address is always wr_ptr_q)
  logic                  fifo_we_c;
  logic [ADDR_W-1:0]     fifo_wdata_c;

  logic                  alloc_ok_c;
  logic                  free_ok_c;
  logic [ADDR_W-1:0]     head_idx_c;

  assign head_idx_c = fifo_q[rd_ptr_q];

  // Next-state, storage updates and registered-output next values
  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    in_use_d     = in_use_q;
    gnt_d        = 1'b0;
    idx_d        = idx_q;
    init_done_d  = init_done_q;
    ovf_d        = ovf_q;
    dbl_d        = dbl_q;
    fifo_we_c    = 1'b0;
    fifo_wdata_c = '0;
    alloc_ok_c   = 1'b0;
    free_ok_c    = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        // Seed the FIFO with identity indices; requests are not served.
        fifo_we_c    = 1'b1;
        fifo_wdata_c = wr_ptr_q;
        wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
        cnt_d        = cnt_q + CNT_W'(1);
        if (bus.free_req_i) begin
          ovf_d = 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end

      ST_READY: begin
        alloc_ok_c = bus.alloc_req_i && (cnt_q != '0);

        if (bus.free_req_i) begin
          if (!in_use_q[bus.free_block_idx_i]) begin
            dbl_d = 1'b1;
          end
          if (cnt_q == CNT_FULL) begin
            ovf_d = 1'b1;
          end
          free_ok_c = in_use_q[bus.free_block_idx_i] && (cnt_q != CNT_FULL);
        end

        // Head index is free while the freed index is in use, so the two
        // bitmap updates never target the same bit.
        if (alloc_ok_c) begin
          gnt_d                = 1'b1;
          idx_d                = head_idx_c;
          rd_ptr_d             = rd_ptr_q + ADDR_W'(1);
          in_use_d[head_idx_c] = 1'b1;
        end

        if (free_ok_c) begin
          fifo_we_c                      = 1'b1;
          fifo_wdata_c                   = bus.free_block_idx_i;
          wr_ptr_d                       = wr_ptr_q + ADDR_W'(1);
          in_use_d[bus.free_block_idx_i] = 1'b0;
        end

        cnt_d = cnt_q + CNT_W'(free_ok_c) - CNT_W'(alloc_ok_c);
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control/state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      in_use_q    <= '0;
      gnt_q       <= 1'b0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      dbl_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      in_use_q    <= in_use_d;
      gnt_q       <= gnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      ovf_q       <= ovf_d;
      dbl_q       <= dbl_d;
    end
  end

  // FIFO storage; contents are rebuilt by INIT so it needs no reset
  always_ff @(posedge clk) begin
    if (fifo_we_c && !rst) begin
      fifo_q[wr_ptr_q] <= fifo_wdata_c;
    end
  end

  assign bus.alloc_gnt_o       = gnt_q;
  assign bus.alloc_block_idx_o = idx_q;
  assign bus.init_done_o       = init_done_q;
  assign bus.free_count_o      = cnt_q;
  assign bus.overflow_err_o    = ovf_q;
  assign bus.double_free_err_o = dbl_q;

endmodule

// File: tb/tb_free_list.sv
// ---------------------------------------------------------------------------
// tb_free_list: directed bench for free_list with NUM_BLOCKS=8.
// Table rows give the inputs applied for one clock edge and the outputs
// expected just after that edge. Reset/init and mid-run reset are sequences.
// ---------------------------------------------------------------------------
module tb_free_list;

  localparam int unsigned NB = 8;
  localparam int unsigned AW = 3;

  logic clk;
  logic rst;

  free_list_if #(.NUM_BLOCKS(NB), .ADDR_W(AW)) bus ();

  free_list #(.NUM_BLOCKS(NB), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          alloc;
    logic          free;
    logic [AW-1:0] fidx;
    logic          gnt;
    logic [AW-1:0] gidx;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          dbl;
  } vec_t;

  vec_t vq[$];
  int   checks;
  int   errors;

  function automatic void add_vec(input logic a, input logic f, input logic [AW-1:0] fi,
                                  input logic g, input logic [AW-1:0] gi,
                                  input logic [AW:0] c, input logic o, input logic d);
    vec_t v;
    v.alloc = a; v.free = f; v.fidx = fi;
    v.gnt = g; v.gidx = gi; v.cnt = c; v.ovf = o; v.dbl = d;
    vq.push_back(v);
  endfunction

  task automatic check(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", nm, tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic f, input logic [AW-1:0] fi);
    bus.alloc_req_i      = a;
    bus.free_req_i       = f;
    bus.free_block_idx_i = fi;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      drive(vq[i].alloc, vq[i].free, vq[i].fidx);
      step();
      check("gnt", i, 32'(bus.alloc_gnt_o), 32'(vq[i].gnt));
      if (vq[i].gnt) check("idx", i, 32'(bus.alloc_block_idx_o), 32'(vq[i].gidx));
      check("count", i, 32'(bus.free_count_o), 32'(vq[i].cnt));
      check("ovf", i, 32'(bus.overflow_err_o), 32'(vq[i].ovf));
      check("dbl", i, 32'(bus.double_free_err_o), 32'(vq[i].dbl));
      check("init_done", i, 32'(bus.init_done_o), 32'd1);
    end
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic check_reset_state(input int tag);
    check("rst_gnt", tag, 32'(bus.alloc_gnt_o), 32'd0);
    check("rst_idx", tag, 32'(bus.alloc_block_idx_o), 32'd0);
    check("rst_count", tag, 32'(bus.free_count_o), 32'd0);
    check("rst_init_done", tag, 32'(bus.init_done_o), 32'd0);
    check("rst_ovf", tag, 32'(bus.overflow_err_o), 32'd0);
    check("rst_dbl", tag, 32'(bus.double_free_err_o), 32'd0);
  endtask

  // Reset, then eight INIT edges with alloc held high; no grants allowed.
  task automatic reset_and_init(input int tag);
    rst = 1'b1;
    drive(1'b1, 1'b0, '0);
    step();
    check_reset_state(tag);
    rst = 1'b0;
    for (int k = 1; k <= int'(NB); k++) begin
      step();
      check("init_gnt", tag * 100 + k, 32'(bus.alloc_gnt_o), 32'd0);
      check("init_count", tag * 100 + k, 32'(bus.free_count_o), 32'(k));
      check("init_done", tag * 100 + k, 32'(bus.init_done_o), (k == int'(NB)) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 1'b0, '0);
  endtask

  int a_lo, a_hi, b_lo, b_hi;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, '0);

    // Phase A: drain all eight blocks, then empty + free + pending alloc.
    a_lo = vq.size();
    for (int i = 0; i < int'(NB); i++)
      add_vec(1, 0, 0, 1, AW'(i), 4'(7 - i), 0, 0);
    add_vec(1, 0, 0, 0, 0, 0, 0, 0);           // 9th request stays pending
    add_vec(1, 1, 5, 0, 0, 1, 0, 0);           // free 5 while empty: accepted, no grant
    add_vec(1, 0, 0, 1, 5, 0, 0, 0);           // pending request gets idx 5
    a_hi = vq.size();

    // Phase B (fresh fill): simultaneous alloc/free, FIFO wrap, error flags.
    b_lo = vq.size();
    for (int i = 0; i < 4; i++)
      add_vec(1, 0, 0, 1, AW'(i), 4'(7 - i), 0, 0);
    add_vec(1, 1, 2, 1, 4, 4, 0, 0);           // grant 4 and free 2 together
    add_vec(1, 0, 0, 1, 5, 3, 0, 0);
    add_vec(1, 0, 0, 1, 6, 2, 0, 0);
    add_vec(1, 0, 0, 1, 7, 1, 0, 0);
    add_vec(1, 0, 0, 1, 2, 0, 0, 0);           // freed 2 comes back after wrap
    add_vec(0, 1, 3, 0, 0, 1, 0, 0);           // free 3 accepted
    add_vec(0, 1, 3, 0, 0, 1, 0, 1);           // free 3 again: double free
    add_vec(0, 1, 0, 0, 0, 2, 0, 1);
    add_vec(0, 1, 1, 0, 0, 3, 0, 1);
    add_vec(0, 1, 2, 0, 0, 4, 0, 1);
    add_vec(0, 1, 4, 0, 0, 5, 0, 1);
    add_vec(0, 1, 5, 0, 0, 6, 0, 1);
    add_vec(0, 1, 6, 0, 0, 7, 0, 1);
    add_vec(0, 1, 7, 0, 0, 8, 0, 1);           // now full
    add_vec(0, 1, 0, 0, 0, 8, 1, 1);           // free while full: overflow
    add_vec(0, 0, 0, 0, 0, 8, 1, 1);           // flags stay set
    add_vec(1, 0, 0, 1, 3, 7, 1, 1);           // head of refilled FIFO is 3
    b_hi = vq.size();

    reset_and_init(1);
    run_rows(a_lo, a_hi);

    reset_and_init(2);
    run_rows(b_lo, b_hi);

    // Mid-run reset during back-to-back allocation (FIFO head is now 0, 1).
    drive(1'b1, 1'b0, '0);
    step();
    check("b2b_gnt", 1, 32'(bus.alloc_gnt_o), 32'd1);
    check("b2b_idx", 1, 32'(bus.alloc_block_idx_o), 32'd0);
    step();
    check("b2b_idx", 2, 32'(bus.alloc_block_idx_o), 32'd1);
    check("b2b_count", 2, 32'(bus.free_count_o), 32'd5);
    rst = 1'b1;
    step();
    check_reset_state(3);
    rst = 1'b0;
    for (int k = 1; k <= int'(NB); k++) begin
      drive(1'b1, (k == 3), 3'd0);
      step();
      check("reinit_gnt", k, 32'(bus.alloc_gnt_o), 32'd0);
      if (k >= 3) check("reinit_ovf", k, 32'(bus.overflow_err_o), 32'd1);
      else        check("reinit_ovf", k, 32'(bus.overflow_err_o), 32'd0);
    end
    check("reinit_done", 0, 32'(bus.init_done_o), 32'd1);
    check("reinit_count", 0, 32'(bus.free_count_o), 32'd8);
    step();
    check("restart_gnt", 0, 32'(bus.alloc_gnt_o), 32'd1);
    check("restart_idx", 0, 32'(bus.alloc_block_idx_o), 32'd0);
    step();
    check("restart_idx", 1, 32'(bus.alloc_block_idx_o), 32'd1);
    check("restart_count", 1, 32'(bus.free_count_o), 32'd6);
    check("restart_ovf", 1, 32'(bus.overflow_err_o), 32'd1);
    check("restart_dbl", 1, 32'(bus.double_free_err_o), 32'd0);
    drive(1'b0, 1'b0, '0);
    step();
    check("idle_gnt", 0, 32'(bus.alloc_gnt_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
